// File: rtl/on_clk_fifo_pkg.sv
// Shared constants and types for the on_clk_fifo single-clock FIFO.
// Optional build macro: ON_CLK_FIFO_ERR_FLAG_EN (sticky ovf/udf outputs).
package on_clk_fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

    typedef logic [DEFAULT_DATA_W-1:0] data_t;

endpackage

// File: rtl/on_clk_fifo_sync_if.sv
// Producer/consumer bus of the on_clk_fifo_sync FIFO.
// Optional build macro: ON_CLK_FIFO_ERR_FLAG_EN adds the sticky ovf/udf flags.
interface on_clk_fifo_sync_if
    import on_clk_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic              write;
    logic              read;
    logic [DATA_W-1:0] iData;
    logic [DATA_W-1:0] oData;
    logic              full;
    logic              empty;
`ifdef ON_CLK_FIFO_ERR_FLAG_EN
    logic              ovf;
    logic              udf;
`endif

`ifdef ON_CLK_FIFO_ERR_FLAG_EN
    modport master (
        output write, read, iData,
        input  oData, full, empty, ovf, udf
    );

    modport slave (
        input  write, read, iData,
        output oData, full, empty, ovf, udf
    );
`else
    modport master (
        output write, read, iData,
        input  oData, full, empty
    );

    modport slave (
        input  write, read, iData,
        output oData, full, empty
    );
`endif

endinterface

// File: rtl/on_clk_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// combinational read port. Contents are never reset.
module on_clk_fifo_mem
    import on_clk_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] word_arr [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_W-1:0] word_reg;

            // Capture write data when this word is the write target.
            always_ff @(posedge CLK) begin
                if (we && (waddr == ADDR_W'(gi))) begin
                    word_reg <= wdata;
                end
            end

            assign word_arr[gi] = word_reg;
        end
    endgenerate

    assign rdata = word_arr[raddr];

endmodule

// File: rtl/on_clk_fifo_sync.sv
// Single-clock synchronous FIFO with registered full/empty flags and a
// registered read-data output. Writes while full and reads while empty are
// silently dropped. RSTn is synchronous and asserted high.
// Optional build macro: ON_CLK_FIFO_ERR_FLAG_EN adds sticky ovf/udf outputs.
module on_clk_fifo_sync
    import on_clk_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RSTn,
    on_clk_fifo_sync_if.slave bus
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W-1:0] rptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic              full_reg;
    logic              empty_reg;
    logic [DATA_W-1:0] odata_reg;
    logic [DATA_W-1:0] rd_word;
    logic              wr_en;
    logic              rd_en;
    logic              mem_we;

    // Accepted strobes use the registered flags seen at this edge.
    assign wr_en  = bus.write & ~full_reg;
    assign rd_en  = bus.read  & ~empty_reg;
    assign mem_we = wr_en & ~RSTn;

    on_clk_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .CLK   (CLK),
        .we    (mem_we),
        .waddr (wptr_reg),
        .wdata (bus.iData),
        .raddr (rptr_reg),
        .rdata (rd_word)
    );

    // Occupancy moves only when exactly one side is accepted.
    always_comb begin
        count_next = count_reg;
        if (wr_en && !rd_en) begin
            count_next = count_reg + CNT_ONE;
        end else if (rd_en && !wr_en) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    // Pointers, occupancy, flags and read data; flags come from the next
    // count so they line up with the pointers after the same edge.
    always_ff @(posedge CLK) begin
        if (RSTn) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
            odata_reg <= '0;
        end else begin
            if (wr_en) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            if (rd_en) begin
                rptr_reg  <= rptr_reg + PTR_ONE;
                odata_reg <= rd_word;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == FULL_COUNT);
            empty_reg <= (count_next == '0);
        end
    end

    assign bus.oData = odata_reg;
    assign bus.full  = full_reg;
    assign bus.empty = empty_reg;

`ifdef ON_CLK_FIFO_ERR_FLAG_EN
    logic ovf_reg;
    logic udf_reg;

    // Sticky misuse flags: set on a rejected strobe, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RSTn) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            if (bus.write && full_reg) begin
                ovf_reg <= 1'b1;
            end
            if (bus.read && empty_reg) begin
                udf_reg <= 1'b1;
            end
        end
    end

    assign bus.ovf = ovf_reg;
    assign bus.udf = udf_reg;
`endif

endmodule

// File: tb/tb_on_clk_fifo_sync.sv
// Self-checking bench for on_clk_fifo_sync: directed scenarios plus random
// traffic, checked against a queue-based model of FIFO behaviour.
module tb_on_clk_fifo_sync;
    import on_clk_fifo_pkg::*;

    localparam int DEPTH = DEFAULT_DEPTH;

    logic CLK;
    logic RSTn;

    on_clk_fifo_sync_if #(.DATA_W(DEFAULT_DATA_W)) bus ();

    on_clk_fifo_sync dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    data_t model_q[$];
    data_t exp_o;
    logic  exp_ovf;
    logic  exp_udf;
    logic  last_rd_ok;
    int    n_checks;
    int    n_pass;
    int    n_step;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d)", tag, got, exp, n_step);
        end
    endtask

    // One clock of stimulus, then model update and output comparison.
    task automatic step(input logic w, input logic r, input data_t d, input logic rst);
        int   sz;
        logic wr_ok;
        logic rd_ok;
        RSTn      = rst;
        bus.write = w;
        bus.read  = r;
        bus.iData = d;
        sz = model_q.size();
        @(posedge CLK);
        #1;
        n_step++;
        rd_ok = 1'b0;
        if (rst) begin
            model_q.delete();
            exp_o   = '0;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            wr_ok = w && (sz < DEPTH);
            rd_ok = r && (sz > 0);
            if (w && sz == DEPTH) exp_ovf = 1'b1;
            if (r && sz == 0)     exp_udf = 1'b1;
            if (rd_ok) exp_o = model_q.pop_front();
            if (wr_ok) model_q.push_back(d);
        end
        last_rd_ok = rd_ok;
        check("oData", bus.oData, exp_o);
        check("empty", bus.empty, model_q.size() == 0);
        check("full",  bus.full,  model_q.size() == DEPTH);
`ifdef ON_CLK_FIFO_ERR_FLAG_EN
        check("ovf", bus.ovf, exp_ovf);
        check("udf", bus.udf, exp_udf);
`endif
        $display("step %0d rst=%0b wr=%0b rd=%0b din=%02h -> dout=%02h empty=%0b full=%0b occ=%0d",
                 n_step, rst, w, r, d, bus.oData, bus.empty, bus.full, model_q.size());
    endtask

    initial begin
        int    pushed;
        data_t seq;
        data_t cnt;
        logic  w;
        logic  r;

        n_checks = 0; n_pass = 0; n_step = 0;
        exp_o = '0; exp_ovf = 1'b0; exp_udf = 1'b0; last_rd_ok = 1'b0;
        RSTn = 1'b1; bus.write = 1'b0; bus.read = 1'b0; bus.iData = '0;

        // Reset held with both strobes active.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'hFF, 1'b1);

        // Fill, then one dropped write.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, data_t'(i), 1'b0);
        step(1'b1, 1'b0, 8'h10, 1'b0);

        // Drain in order, then one ignored read.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            check("drain_order", bus.oData, i);
        end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("hold_after_empty", bus.oData, 8'h0F);

        // Concurrent streaming; output must be contiguous from 0.
        cnt = '0; seq = '0;
        for (int i = 0; i < 13; i++) begin
            w = (i < 10);
            r = (i >= 3);
            step(w, r, cnt, 1'b0);
            if (w) cnt++;
            if (last_rd_ok) begin
                check("seq", bus.oData, seq);
                seq++;
            end
            if (i >= 3 && i < 10) check("occ_const", model_q.size(), 3);
        end

        // Empty with read+write: only the write lands.
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        check("empty_rw_hold", bus.oData, 8'h09);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("empty_rw_data", bus.oData, 8'hA5);

        // Full with read+write: only the read lands.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, data_t'(8'h40 + i), 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        check("full_rw_data", bus.oData, 8'h40);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        check("full_rw_last", bus.oData, 8'h4F);

        // Wrap: 40 bytes with occupancy kept within 1..5.
        pushed = 0;
        while (pushed < 40 || model_q.size() > 0) begin
            w = (pushed < 40) && (model_q.size() < 5) &&
                ((model_q.size() == 0) || ($urandom_range(0, 1) == 1));
            r = (model_q.size() > 1) || (pushed >= 40);
            if (model_q.size() == 1 && pushed < 40) r = 1'b0;
            step(w, r, data_t'($urandom_range(0, 255)), 1'b0);
            if (w) pushed++;
        end

        // Reset with three entries held discards them.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, data_t'(8'hC0 + i), 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("post_rst_odata", bus.oData, 8'h00);
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("post_rst_fresh", bus.oData, 8'h5A);

        // Random traffic including overflow and underflow attempts.
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 30));
            r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
            step(w, r, data_t'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
